// File: rtl/lcd_pkg.sv
// Shared encodings for the AXI-Stream test-pattern generator: FSM states,
// pattern modes and the eight colour-bar constants.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECK   = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/axis_pattern_pixel.sv
// Combinational pixel generator: maps (x, y) and the frame's latched
// mode/colour to either a linear pixel index or a 24-bit RGB value.
module axis_pattern_pixel
  import lcd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int H_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 4,
  parameter int XW         = 9,
  parameter int YW         = 9
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  mode_e             mode,
  input  logic [23:0]       rgb,
  output logic [DATA_W-1:0] pix
);

  localparam int LW    = XW + YW;
  // The last bar absorbs the remainder, so the index is clamped to 7.
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [LW-1:0] lin;
  logic [31:0]   bar_raw;
  logic [2:0]    bar_idx;
  logic [XW-1:0] x_sq;
  logic [YW-1:0] y_sq;
  logic [23:0]   colour;

  always_comb begin
    lin     = LW'(y) * LW'(H_ACTIVE) + LW'(x);
    bar_raw = 32'(x) / 32'(BAR_W);
    bar_idx = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
    x_sq    = x >> CHECK_LOG2;
    y_sq    = y >> CHECK_LOG2;
    case (mode)
      MODE_BARS:  colour = bar_colour(bar_idx);
      MODE_CHECK: colour = (x_sq[0] ^ y_sq[0]) ? 24'h000000 : 24'hFFFFFF;
      default:    colour = rgb;
    endcase
    pix = (mode == MODE_COUNTER) ? DATA_W'(lin) : DATA_W'(colour);
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream video test-pattern source: emits H_ACTIVE x V_ACTIVE frames with
// tuser on the first pixel, tlast per line and optional idle gaps between lines.
module axis_pattern_gen
  import lcd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int LINE_GAP   = 0,
  parameter int CHECK_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [23:0]       solid_rgb,
  output logic [DATA_W-1:0] axis_tdata,
  output logic              axis_tvalid,
  input  logic              axis_tready,
  output logic              axis_tuser,
  output logic              axis_tlast,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  mode_e             mode_q, mode_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] pix;

  logic xfer, last_x, last_y, line_done, frame_done, start;

  assign xfer       = tvalid_q && axis_tready;
  assign last_x     = (x_q == XW'(H_ACTIVE - 1));
  assign last_y     = (y_q == YW'(V_ACTIVE - 1));
  assign line_done  = xfer && last_x;
  assign frame_done = line_done && last_y;
  // A frame starts when pixel (0,0) is about to be loaded; mode/colour latch here.
  assign start      = ((state_q == ST_IDLE) && enable) || frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (line_done) begin
        if (frame_done && !enable) state_d = ST_IDLE;
        else if (LINE_GAP > 0)     state_d = ST_GAP;
      end
      ST_GAP:    if (gap_q == GW'(LINE_GAP - 1)) state_d = ST_ACTIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    rgb_d       = rgb_q;
    gap_d       = '0;
    frame_cnt_d = frame_cnt_q;
    if (line_done) begin
      x_d = '0;
      y_d = last_y ? '0 : y_q + 1'b1;
      if (last_y) frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (xfer) begin
      x_d = x_q + 1'b1;
    end
    if (start) begin
      mode_d = mode_e'(mode);
      rgb_d  = solid_rgb;
    end
    if (state_q == ST_GAP) gap_d = gap_q + 1'b1;
  end

  axis_pattern_pixel #(
    .DATA_W    (DATA_W),
    .H_ACTIVE  (H_ACTIVE),
    .CHECK_LOG2(CHECK_LOG2),
    .XW        (XW),
    .YW        (YW)
  ) u_pixel (
    .x   (x_d),
    .y   (y_d),
    .mode(mode_d),
    .rgb (rgb_d),
    .pix (pix)
  );

  // Outputs are computed from next-state values so every port comes from a flop.
  always_comb begin
    tvalid_d = (state_d == ST_ACTIVE);
    tdata_d  = tvalid_d ? pix : tdata_q;
    tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
    tlast_d  = tvalid_d && (x_d == XW'(H_ACTIVE - 1));
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= MODE_COUNTER;
      rgb_q       <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      rgb_q       <= rgb_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
    end
  end

  assign axis_tdata  = tdata_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tuser  = tuser_q;
  assign axis_tlast  = tlast_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomised-backpressure bench for axis_pattern_gen against a frame-level
// reference model (pixel formulas, line gaps, frame counting, reset restart).
module tb_axis_pattern_gen;

  localparam int DW  = 32;
  localparam int H   = 44;
  localparam int V   = 12;
  localparam int GAP = 3;
  localparam int CL  = 2;
  localparam int FR  = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [23:0]   solid_rgb;
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tready;
  logic          axis_tuser;
  logic          axis_tlast;
  logic [15:0]   frame_cnt;
  logic          busy;

  axis_pattern_gen #(
    .DATA_W    (DW),
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .LINE_GAP  (GAP),
    .CHECK_LOG2(CL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .axis_tdata (axis_tdata),
    .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready),
    .axis_tuser (axis_tuser),
    .axis_tlast (axis_tlast),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          n_tests, n_fail;
  int          ex, ey, beats, frames_done, gap_left, ready_pct;
  bit          expect_valid, idle_exp;
  logic [1:0]  fr_mode;
  logic [23:0] fr_rgb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (x=%0d y=%0d beat=%0d)", tag, got, exp, ex, ey, beats);
    end
  endtask

  function automatic logic [DW-1:0] ref_pix(input int x, input int y, input logic [1:0] m,
                                            input logic [23:0] c);
    int b;
    case (m)
      2'd0: return DW'(y * H + x);
      2'd1: begin
        b = x / (H / 8);
        if (b > 7) b = 7;
        return DW'(bars[b]);
      end
      2'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? DW'(0) : DW'(24'hFFFFFF);
      default: return DW'(c);
    endcase
  endfunction

  // One clock: pick tready, advance the model on a transfer, then check the new outputs.
  task automatic step();
    bit          xfer, en_e, frame_end;
    logic [1:0]  m_e;
    logic [23:0] c_e;
    axis_tready = (int'($urandom_range(99)) < ready_pct);
    xfer      = axis_tvalid && axis_tready;
    en_e      = enable;
    m_e       = mode;
    c_e       = solid_rgb;
    frame_end = 0;
    @(posedge clk);
    #1;
    if (xfer) begin
      beats++;
      if (ex == H - 1) begin
        ex = 0;
        if (ey == V - 1) begin
          ey = 0;
          frames_done++;
          frame_end = 1;
          fr_mode   = m_e;
          fr_rgb    = c_e;
          if (en_e) gap_left = GAP;
          else      idle_exp = 1;
        end else begin
          ey++;
          gap_left = GAP;
        end
      end else begin
        ex++;
      end
    end
    if (frame_end) begin
      check_eq("frame_cnt", 64'(frame_cnt), 64'(frames_done[15:0]));
      $display("[TB] frame done: frame_cnt=%0d beats=%0d", frame_cnt, beats);
    end
    check_eq("busy", 64'(busy), 64'(!idle_exp));
    if (idle_exp) begin
      check_eq("idle_valid", 64'(axis_tvalid), 64'(0));
    end else if (gap_left > 0) begin
      check_eq("gap_valid", 64'(axis_tvalid), 64'(0));
      gap_left--;
      if (gap_left == 0) expect_valid = 1;
    end else if (expect_valid) begin
      check_eq("gap_end", 64'(axis_tvalid), 64'(1));
      expect_valid = 0;
    end
    if (axis_tvalid)
      check_eq("pix", 64'({axis_tuser, axis_tlast, axis_tdata}),
               64'({(ex == 0 && ey == 0), (ex == H - 1), ref_pix(ex, ey, fr_mode, fr_rgb)}));
  endtask

  task automatic model_reset();
    ex = 0; ey = 0; beats = 0; frames_done = 0; gap_left = 0; expect_valid = 0;
  endtask

  task automatic run(input logic [1:0] m, input int pct, input int nfr, input int drop_at,
                     input int chg_at, input logic [1:0] chg_m, input int rst_at);
    int cyc      = 0;
    bit rst_done = 0;
    bit chg_done = 0;
    mode      = m;
    solid_rgb = 24'($urandom);
    fr_mode   = m;
    fr_rgb    = solid_rgb;
    ready_pct = pct;
    beats     = 0;
    idle_exp  = 0;
    enable    = 1;
    while (!idle_exp && cyc < 20000) begin
      step();
      cyc++;
      if (beats == chg_at && !chg_done) begin
        mode      = chg_m;
        solid_rgb = 24'($urandom);
        chg_done  = 1;
      end
      if (beats == drop_at && (rst_at < 0 || rst_done)) enable = 0;
      if (beats == rst_at && !rst_done) begin
        #2 rst = 1;
        #1 check_eq("rst_async", 64'({axis_tvalid, axis_tuser, axis_tlast, axis_tdata, frame_cnt, busy}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #3 rst = 0;
        model_reset();
        fr_mode  = mode;
        fr_rgb   = solid_rgb;
        rst_done = 1;
        step();
        check_eq("rst_restart", 64'({axis_tvalid, axis_tuser, axis_tdata}), 64'({2'b11, 32'd0}));
      end
    end
    check_eq("run_done", 64'(idle_exp), 64'(1));
    check_eq("beats", 64'(beats), 64'(nfr * FR));
    repeat (4) step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 0; enable = 0; mode = 0; solid_rgb = 0; axis_tready = 0; ready_pct = 100;
    model_reset();
    idle_exp = 1; fr_mode = 0; fr_rgb = 0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(axis_tvalid), 64'(0));
    check_eq("rst_tuser",  64'(axis_tuser),  64'(0));
    check_eq("rst_tlast",  64'(axis_tlast),  64'(0));
    check_eq("rst_tdata",  64'(axis_tdata),  64'(0));
    check_eq("rst_fcnt",   64'(frame_cnt),   64'(0));
    check_eq("rst_busy",   64'(busy),        64'(0));
    #2 rst = 0;
    repeat (3) step();

    // mode 0, full throughput, 2 frames; enable drop and mode change mid second frame
    run(2'd0, 100, 2, 1000, 1000, 2'd3, -1);
    // mode 0 with 50% backpressure
    run(2'd0, 50, 1, 100, -1, 2'd0, -1);
    // colour bars
    run(2'd1, 70, 1, 200, -1, 2'd0, -1);
    // checkerboard
    run(2'd2, 50, 1, 300, -1, 2'd0, -1);
    // solid, switched to bars mid frame: next frame must be bars
    run(2'd3, 60, 2, FR + 10, 200, 2'd1, -1);
    // reset mid-frame at beat 300, then one clean frame
    run(2'd0, 80, 1, 100, -1, 2'd0, 300);

    check_eq("final_fcnt", 64'(frame_cnt), 64'(1));
    check_eq("final_busy", 64'(busy), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
